// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: packs big-endian bytes into 32-bit words and writes them
// to instruction memory from address 0 until END_WORD arrives or the memory is full.
module instr_mem_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] END_WORD   = 32'hFFFF_FFFF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_din;
    logic [1:0]            r_byte_idx;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_done;
    logic                  r_overflow;
    logic                  w_start;
    logic                  w_accept;
    logic                  w_is_end;
    logic                  w_at_last;

    assign w_start   = start && (r_state == IDLE || r_state == DONE || r_state == ERROR);
    assign w_accept  = rx_valid && (r_state == RECV);
    assign w_is_end  = (r_din == END_WORD);
    assign w_at_last = (r_addr == LAST_ADDR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b0;
        mem_we   = 1'b0;
        cpu_hold = 1'b0;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (start) w_next = RECV;
            end
            RECV: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
                if (rx_valid && r_byte_idx == 2'd3) w_next = WRITE;
            end
            WRITE: begin
                mem_we   = 1'b1;
                cpu_hold = 1'b1;
                if (w_is_end)       w_next = DONE;
                else if (w_at_last) w_next = ERROR;
                else                w_next = RECV;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr     <= '0;
            r_din      <= '0;
            r_byte_idx <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr     <= '0;
                r_byte_idx <= '0;
                r_count    <= '0;
                r_done     <= 1'b0;
                r_overflow <= 1'b0;
            end
            if (w_accept) begin
                case (r_byte_idx)
                    2'd0:    r_din[31:24] <= rx_data;
                    2'd1:    r_din[23:16] <= rx_data;
                    2'd2:    r_din[15:8]  <= rx_data;
                    default: r_din[7:0]   <= rx_data;
                endcase
                r_byte_idx <= r_byte_idx + 2'd1;
            end
            if (r_state == WRITE) begin
                r_count <= r_count + (ADDR_WIDTH+1)'(1);
                // The end marker is itself written so the CPU halts on it; the address stays put.
                if (w_is_end) begin
                    r_done <= 1'b1;
                end else if (w_at_last) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_addr     <= r_addr + ADDR_WIDTH'(1);
                    r_byte_idx <= '0;
                end
            end
        end
    end

    assign mem_addr   = r_addr;
    assign mem_din    = r_din;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign word_count = r_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: expected memory writes are queued as bytes are
// sent and retired by a write monitor; state/flag checks are made at falling edges.
module tb_instr_mem_loader;
    localparam int AW = 10;

    logic          clock    = 1'b0;
    logic          reset_n  = 1'b0;
    logic          start    = 1'b0;
    logic [7:0]    rx_data  = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic          cpu_hold;
    logic          done;
    logic          overflow;
    logic [AW:0]   word_count;

    int errors = 0;
    int checks = 0;
    int nwr    = 0;
    logic [AW+31:0] sb[$];

    instr_mem_loader #(.ADDR_WIDTH(AW), .END_WORD(32'hFFFF_FFFF)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .cpu_hold(cpu_hold), .done(done), .overflow(overflow),
        .word_count(word_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every mem_we cycle must retire the oldest queued write.
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            logic [AW+31:0] e;
            nwr++;
            chk("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("write_addr", 64'(mem_addr), 64'(e[AW+31:32]));
                chk("write_data", 64'(mem_din), 64'(e[31:0]));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n == 20) chk("rx_ready_timeout", 64'(rx_ready), 64'd1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    // gap=1 idles two cycles after each byte, pulsing start in the first of them.
    task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w, input bit gap);
        sb.push_back({a, w});
        for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8]);
            if (gap) begin
                pulse_start();
                @(negedge clock);
            end
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("done_wait", 64'(done), 64'd1);
    endtask

    task automatic offer_bytes_blocked(input string tag);
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk(tag, 64'(rx_ready), 64'd0);
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        chk("rst_flags", 64'({rx_ready, mem_we, cpu_hold, done, overflow}), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_din", 64'(mem_din), 64'd0);
        chk("rst_count", 64'(word_count), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Bytes offered in IDLE are refused
        offer_bytes_blocked("idle_rx_ready");
        chk("idle_count", 64'(word_count), 64'd0);

        // Basic program: one word plus end marker
        pulse_start();
        chk("recv_hold", 64'({cpu_hold, rx_ready}), 64'h3);
        send_word(10'd0, 32'h2001_0005, 1'b0);
        send_word(10'd1, 32'hFFFF_FFFF, 1'b0);
        chk("write_hold", 64'({cpu_hold, done}), 64'h2);
        @(negedge clock);
        chk("basic_done", 64'({done, cpu_hold, overflow}), 64'h4);
        chk("basic_count", 64'(word_count), 64'd2);
        chk("basic_nwr", 64'(nwr), 64'd2);

        // DONE ignores bytes; restart clears flags and reloads from 0 with gaps and stray starts
        offer_bytes_blocked("done_rx_ready");
        pulse_start();
        chk("restart_clear", 64'({done, word_count}), 64'd0);
        send_word(10'd0, 32'h1234_5678, 1'b1);
        send_word(10'd1, 32'hDEAD_BEEF, 1'b1);
        send_word(10'd2, 32'hFFFF_FFFF, 1'b1);
        wait_done();
        chk("gap_count", 64'(word_count), 64'd3);
        chk("gap_nwr", 64'(nwr), 64'd5);

        // Reset mid-word discards the partial word
        pulse_start();
        send_word(10'd0, 32'hA000_0001, 1'b0);
        send_word(10'd1, 32'hA000_0002, 1'b0);
        send_word(10'd2, 32'hA000_0003, 1'b0);
        send_byte(8'h55);
        send_byte(8'h66);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_flags", 64'({rx_ready, mem_we, cpu_hold, done, overflow}), 64'd0);
        chk("mid_rst_addr", 64'(mem_addr), 64'd0);
        chk("mid_rst_din", 64'(mem_din), 64'd0);
        chk("mid_rst_count", 64'(word_count), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("post_rst_idle", 64'({cpu_hold, rx_ready}), 64'd0);
        pulse_start();
        send_word(10'd0, 32'hCAFE_F00D, 1'b0);
        send_word(10'd1, 32'hFFFF_FFFF, 1'b0);
        wait_done();
        chk("reload_count", 64'(word_count), 64'd2);

        // Fill the whole memory without an end marker
        pulse_start();
        for (int i = 0; i < 1024; i++) send_word(AW'(i), 32'h0100_0000 + 32'(i), 1'b0);
        @(negedge clock);
        chk("ovf_flags", 64'({overflow, done, cpu_hold, rx_ready}), 64'h8);
        chk("ovf_count", 64'(word_count), 64'd1024);
        chk("ovf_addr", 64'(mem_addr), 64'd1023);
        offer_bytes_blocked("error_rx_ready");
        chk("ovf_flag_hold", 64'(overflow), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("total_nwr", 64'(nwr), 64'd1034);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
